// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: sequencer state encoding, default timing and a small helper.
package pwr_seq_pkg;
   typedef enum logic [3:0] {
      S_OFF, S_SW_ON, S_RESTORE, S_LS_EN, S_DEISO, S_ON, S_ISO, S_SAVE, S_SW_OFF
   } pwr_state_e;
   localparam int DEF_ISO_SETUP   = 4;
   localparam int DEF_SAVE_CYC    = 2;
   localparam int DEF_RESTORE_CYC = 2;
   localparam int DEF_LS_SETTLE   = 3;
   localparam int DEF_ACK_TIMEOUT = 16;
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], d_i};
   assign q_o = sync_q[1];
endmodule

// File: rtl/pwr_domain_seq.sv
// pwr_domain_seq: orders isolation, retention, level shifters and the header
// switch for one switchable domain, with an ack timeout on the switch.
module pwr_domain_seq
   import pwr_seq_pkg::*;
#(
   parameter int ISO_SETUP   = DEF_ISO_SETUP,
   parameter int SAVE_CYC    = DEF_SAVE_CYC,
   parameter int RESTORE_CYC = DEF_RESTORE_CYC,
   parameter int LS_SETTLE   = DEF_LS_SETTLE,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwr_down_req,
   input  logic pwr_up_req,
   input  logic pwr_ack,
   input  logic err_clr,
   output logic iso_en,
   output logic ls_en,
   output logic save,
   output logic restore,
   output logic pwr_sw_en,
   output logic domain_on,
   output logic busy,
   output logic timeout_err
);
   localparam int MAXP = max2(max2(max2(ISO_SETUP, SAVE_CYC), max2(RESTORE_CYC, LS_SETTLE)), ACK_TIMEOUT);
   localparam int CW   = $clog2(MAXP) + 1;

   pwr_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d, to_err, ack_s, done;

   sync_2ff u_ack_sync (.clk(clk), .rst_n(rst_n), .d_i(pwr_ack), .q_o(ack_s));

   // Counter is loaded with N-1 on entry so a timed state lasts exactly N cycles.
   function automatic logic [CW-1:0] load(input pwr_state_e s);
      return (s inside {S_SW_ON, S_SW_OFF}) ? CW'(ACK_TIMEOUT - 1) :
             (s == S_RESTORE)               ? CW'(RESTORE_CYC - 1) :
             (s == S_LS_EN)                 ? CW'(LS_SETTLE - 1)   :
             (s == S_ISO)                   ? CW'(ISO_SETUP - 1)   :
             (s == S_SAVE)                  ? CW'(SAVE_CYC - 1)    : '0;
   endfunction

   assign done = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      to_err  = 1'b0;
      case (state_q)
         S_OFF:     if (pwr_up_req) state_d = S_SW_ON;
         S_SW_ON:   if (ack_s) state_d = S_RESTORE;
                    else if (done) begin
                       state_d = S_OFF;
                       to_err  = 1'b1;
                    end
         S_RESTORE: if (done) state_d = S_LS_EN;
         S_LS_EN:   if (done) state_d = S_DEISO;
         S_DEISO:   state_d = S_ON;
         S_ON:      if (pwr_down_req) state_d = S_ISO;
         S_ISO:     if (done) state_d = S_SAVE;
         S_SAVE:    if (done) state_d = S_SW_OFF;
         S_SW_OFF:  if (!ack_s) state_d = S_OFF;
                    else if (done) begin
                       state_d = S_OFF;
                       to_err  = 1'b1;
                    end
         default:   state_d = S_OFF;
      endcase
      cnt_d = (state_d != state_q) ? load(state_d) : (done ? cnt_q : cnt_q - CW'(1));
      err_d = to_err | (err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end

   assign iso_en      = !(state_q inside {S_DEISO, S_ON});
   assign ls_en       = state_q inside {S_LS_EN, S_DEISO, S_ON};
   assign save        = (state_q == S_SAVE);
   assign restore     = (state_q == S_RESTORE);
   assign pwr_sw_en   = !(state_q inside {S_OFF, S_SW_OFF});
   assign domain_on   = (state_q == S_ON);
   assign busy        = !(state_q inside {S_OFF, S_ON});
   assign timeout_err = err_q;
endmodule
